// File: rtl/exu_mul_sched_if.sv
// rtl/exu_mul_sched_if.sv - multiplier issue packet type and scheduler port bundle
package exu_mul_sched_pkg;
    typedef struct packed {
        logic valid;
        logic rs1_sign;
        logic rs2_sign;
        logic low;
        logic load_mul_rs1_bypass_e1;
        logic load_mul_rs2_bypass_e1;
    } mul_pkt_t;
endpackage

interface exu_mul_sched_if #(
    parameter int TAG_W = 5
);
    import exu_mul_sched_pkg::*;

    logic             freeze;
    logic             i0_req;
    logic             i0_rs1_sign;
    logic             i0_rs2_sign;
    logic             i0_low;
    logic             i0_ld_byp1;
    logic             i0_ld_byp2;
    logic [TAG_W-1:0] i0_tag;
    logic             i0_gnt;
    logic             i1_req;
    logic             i1_rs1_sign;
    logic             i1_rs2_sign;
    logic             i1_low;
    logic             i1_ld_byp1;
    logic             i1_ld_byp2;
    logic [TAG_W-1:0] i1_tag;
    logic             i1_gnt;
    mul_pkt_t         mp;
    logic             op_sel;
    logic             flush_e1;
    logic             flush_e2;
    logic [TAG_W-1:0] busy_tag_q;
    logic             busy_hit;
    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic             res_slot;

    modport master (
        output freeze,
        output i0_req, i0_rs1_sign, i0_rs2_sign, i0_low, i0_ld_byp1, i0_ld_byp2, i0_tag,
        output i1_req, i1_rs1_sign, i1_rs2_sign, i1_low, i1_ld_byp1, i1_ld_byp2, i1_tag,
        output flush_e1, flush_e2, busy_tag_q,
        input  i0_gnt, i1_gnt, mp, op_sel, busy_hit, res_valid, res_tag, res_slot
    );

    modport slave (
        input  freeze,
        input  i0_req, i0_rs1_sign, i0_rs2_sign, i0_low, i0_ld_byp1, i0_ld_byp2, i0_tag,
        input  i1_req, i1_rs1_sign, i1_rs2_sign, i1_low, i1_ld_byp1, i1_ld_byp2, i1_tag,
        input  flush_e1, flush_e2, busy_tag_q,
        output i0_gnt, i1_gnt, mp, op_sel, busy_hit, res_valid, res_tag, res_slot
    );
endinterface

// File: rtl/exu_mul_sched.sv
// rtl/exu_mul_sched.sv - issue scheduler/tracker for the 3-stage multiplier; RV_MUL_SCHED_PERF_EN adds perf counters
module exu_mul_sched
    import exu_mul_sched_pkg::*;
#(
    parameter int TAG_W = 5
`ifdef RV_MUL_SCHED_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    exu_mul_sched_if.slave   bus
`ifdef RV_MUL_SCHED_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_issue,
    output logic [CNT_W-1:0] perf_conflict
`endif
);

    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
        logic             slot;
    } stage_t;

    stage_t   s1_q, s2_q, s3_q;
    stage_t   s1_n, s2_n, s3_n;
    stage_t   grant_e;
    logic     gnt0, gnt1;
    logic     kill_s1, kill_s2;
    mul_pkt_t mp_c;
    logic     busy_c;

    // Fixed priority: i0 is older in program order; reset masks grants immediately.
    always_comb begin
        gnt0 = bus.i0_req & ~bus.freeze & ~rst;
        gnt1 = bus.i1_req & ~bus.i0_req & ~bus.freeze & ~rst;
    end

    always_comb begin
        mp_c = '0;
        if (gnt0) begin
            mp_c.valid                  = 1'b1;
            mp_c.rs1_sign               = bus.i0_rs1_sign;
            mp_c.rs2_sign               = bus.i0_rs2_sign;
            mp_c.low                    = bus.i0_low;
            mp_c.load_mul_rs1_bypass_e1 = bus.i0_ld_byp1;
            mp_c.load_mul_rs2_bypass_e1 = bus.i0_ld_byp2;
        end else if (gnt1) begin
            mp_c.valid                  = 1'b1;
            mp_c.rs1_sign               = bus.i1_rs1_sign;
            mp_c.rs2_sign               = bus.i1_rs2_sign;
            mp_c.low                    = bus.i1_low;
            mp_c.load_mul_rs1_bypass_e1 = bus.i1_ld_byp1;
            mp_c.load_mul_rs2_bypass_e1 = bus.i1_ld_byp2;
        end
    end

    always_comb begin
        grant_e      = '0;
        grant_e.v    = gnt0 | gnt1;
        grant_e.slot = gnt1;
        if (gnt0) begin
            grant_e.tag = bus.i0_tag;
        end else if (gnt1) begin
            grant_e.tag = bus.i1_tag;
        end
    end

    // flush_e2 reaches back into E1 as well; the entry being granted now is never killed.
    always_comb begin
        kill_s1 = bus.flush_e1 | bus.flush_e2;
        kill_s2 = bus.flush_e2;
    end

    always_comb begin
        s1_n = s1_q;
        s2_n = s2_q;
        s3_n = s3_q;
        if (!bus.freeze) begin
            s1_n   = grant_e;
            s2_n   = s1_q;
            s2_n.v = s1_q.v & ~kill_s1;
            s3_n   = s2_q;
            s3_n.v = s2_q.v & ~kill_s2;
        end else begin
            s1_n.v = s1_q.v & ~kill_s1;
            s2_n.v = s2_q.v & ~kill_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_n;
            s2_q <= s2_n;
            s3_q <= s3_n;
        end
    end

    // Tag 0 is the hardwired-zero register and never creates a dependency.
    always_comb begin
        busy_c = 1'b0;
        if (bus.busy_tag_q != '0) begin
            busy_c = (s1_q.v && (s1_q.tag == bus.busy_tag_q)) ||
                     (s2_q.v && (s2_q.tag == bus.busy_tag_q)) ||
                     (s3_q.v && (s3_q.tag == bus.busy_tag_q));
        end
    end

    assign bus.i0_gnt    = gnt0;
    assign bus.i1_gnt    = gnt1;
    assign bus.mp        = mp_c;
    assign bus.op_sel    = gnt1;
    assign bus.busy_hit  = busy_c;
    assign bus.res_valid = s3_q.v & ~bus.freeze;
    assign bus.res_tag   = s3_q.tag;
    assign bus.res_slot  = s3_q.slot;

`ifdef RV_MUL_SCHED_PERF_EN
    logic [CNT_W-1:0] issue_q, conflict_q;
    logic             conflict_c;

    assign conflict_c = bus.i0_req & bus.i1_req & ~bus.freeze;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_q    <= '0;
            conflict_q <= '0;
        end else begin
            if ((gnt0 | gnt1) && !(&issue_q)) begin
                issue_q <= issue_q + 1'b1;
            end
            if (conflict_c && !(&conflict_q)) begin
                conflict_q <= conflict_q + 1'b1;
            end
        end
    end

    assign perf_issue    = issue_q;
    assign perf_conflict = conflict_q;
`endif

endmodule
